beat_note_scheduler: RTL and testbench

Consumer stage downstream of the beatmap note generator (data_en/data byte stream of note codes 60..76, step 4). Buffers incoming note codes in a small FIFO and releases one note per beat tick, converting each note code to a lane index for the falling-note renderer. Sits between the beatmap generator and the lane/display logic.

---
 rtl/beat_note_scheduler_pkg.sv | 33 +++
 rtl/beat_note_scheduler_fifo.sv | 71 +++++++
 rtl/beat_note_scheduler.sv | 176 +++++++++++++++++
 tb/tb_beat_note_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_note_scheduler_pkg.sv
// beat_note_scheduler_pkg
//   Shared definitions for the beat note scheduler:
//   - sched_state_t : scheduler FSM states (IDLE, ARMED, EMIT)
//   - default note mapping (base code, code step, lane count)
//   - LANE_W        : width of the lane index
//   - note_code_valid(): tells whether a note code maps onto a lane
package beat_note_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        EMIT  = 2'd2
    } sched_state_t;

    localparam int NOTE_BASE_DEF = 60;
    localparam int NOTE_STEP_DEF = 4;
    localparam int NUM_LANES_DEF = 5;
    localparam int LANE_W        = 3;

    // The lower bound is checked first so the subtraction never wraps.
    function automatic logic note_code_valid(input logic [7:0] code,
                                             input int base,
                                             input int step,
                                             input int lanes);
        int off;
        if (int'(code) < base) begin
            return 1'b0;
        end
        off = int'(code) - base;
        return ((off % step) == 0) && ((off / step) < lanes);
    endfunction

endpackage

// File: rtl/beat_note_scheduler_fifo.sv
// sched_fifo
//   Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//   Ports:
//     clk   : clock, rising edge
//     rst   : synchronous active-high reset, empties the FIFO
//     push  : write din (ignored when full unless popping the same cycle)
//     pop   : advance the head (ignored when empty)
//     din   : write data
//     dout  : head entry, valid while empty = 0
//     full  : count == DEPTH
//     empty : count == 0
//     count : current occupancy, 0..DEPTH
module sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/beat_note_scheduler.sv
// beat_note_scheduler
//   Buffers note codes from the beatmap generator and releases one note per
//   beat tick, translating the code into a lane index for the renderer.
//   Optional build macro: SCHED_DROP_COUNT_EN adds drop_count[7:0].
//   Ports:
//     clk        : clock, rising edge
//     resetn     : synchronous reset, ACTIVE HIGH (1 = reset)
//     data_en    : upstream note strobe
//     data       : upstream note code
//     pause      : freezes the beat counter, no new notes are released
//     note_valid : one-cycle pulse, note/lane carry an emitted note
//     note       : last emitted note code
//     lane       : last emitted lane index
//     fifo_count : notes currently buffered
//     overflow   : sticky, a valid note was dropped on a full FIFO
//     bad_note   : one-cycle pulse, an invalid code was discarded
//     drop_count : (SCHED_DROP_COUNT_EN) dropped + bad notes, saturating
//   Valid/ready: upstream has no ready; every data_en cycle is consumed,
//   either stored, dropped (overflow) or rejected (bad_note).
module beat_note_scheduler #(
    parameter int DEPTH     = 8,
    parameter int BEAT_DIV  = 12500000,
    parameter int NOTE_BASE = 60,
    parameter int NOTE_STEP = 4,
    parameter int NUM_LANES = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     data_en,
    input  logic [7:0]               data,
    input  logic                     pause,
    output logic                     note_valid,
    output logic [7:0]               note,
    output logic [2:0]               lane,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     bad_note
`ifdef SCHED_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    import beat_note_scheduler_pkg::*;

    localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [CNT_W-1:0] beat_q;
    logic             tick;
    logic             pop;
    logic             push;
    logic             code_ok;
    logic             drop_valid;
    logic             drop_bad;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [7:0]       lane_wide;
    logic [7:0]       note_q;
    logic [2:0]       lane_q;
    logic             overflow_q;
    logic             bad_q;

    assign code_ok    = note_code_valid(data, NOTE_BASE, NOTE_STEP, NUM_LANES);
    assign tick       = (beat_q == CNT_W'(BEAT_DIV - 1)) && !pause;
    assign push       = data_en && code_ok && (!fifo_full || pop);
    assign drop_valid = data_en && code_ok && fifo_full && !pop;
    assign drop_bad   = data_en && !code_ok;
    // Head entries always passed validation, so this never underflows.
    assign lane_wide  = (fifo_dout - 8'(NOTE_BASE)) / 8'(NOTE_STEP);

    sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (resetn),
        .push  (push),
        .pop   (pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Beat counter: free-running modulo BEAT_DIV, frozen while paused.
    always_ff @(posedge clk) begin
        if (resetn) begin
            beat_q <= '0;
        end else if (!pause) begin
            if (beat_q == CNT_W'(BEAT_DIV - 1)) begin
                beat_q <= '0;
            end else begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE and EMIT look at the registered occupancy, so a note written
    // while in IDLE needs one cycle before ARMED can catch a tick.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (tick) begin
                    pop     = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                state_d = (fifo_count != '0) ? ARMED : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // note/lane are captured at pop time and hold until the next pop.
    always_ff @(posedge clk) begin
        if (resetn) begin
            note_q     <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            if (pop) begin
                note_q <= fifo_dout;
                lane_q <= lane_wide[LANE_W-1:0];
            end
            if (drop_valid) begin
                overflow_q <= 1'b1;
            end
            bad_q <= drop_bad;
        end
    end

    assign note_valid = (state_q == EMIT);
    assign note       = note_q;
    assign lane       = lane_q;
    assign overflow   = overflow_q;
    assign bad_note   = bad_q;

`ifdef SCHED_DROP_COUNT_EN
    logic [7:0] drop_q;

    // An input is either dropped on full or rejected as bad, never both.
    always_ff @(posedge clk) begin
        if (resetn) begin
            drop_q <= '0;
        end else if ((drop_valid || drop_bad) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_beat_note_scheduler.sv
module tb_beat_note_scheduler;

    localparam int DEPTH     = 8;
    localparam int BEAT_DIV  = 4;
    localparam int NOTE_BASE = 60;
    localparam int NOTE_STEP = 4;
    localparam int NUM_LANES = 5;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       resetn;
    logic       data_en;
    logic [7:0] data;
    logic       pause;
    logic       note_valid;
    logic [7:0] note;
    logic [2:0] lane;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       bad_note;
`ifdef SCHED_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    always #5 clk = ~clk;

    beat_note_scheduler #(
        .DEPTH     (DEPTH),
        .BEAT_DIV  (BEAT_DIV),
        .NOTE_BASE (NOTE_BASE),
        .NOTE_STEP (NOTE_STEP),
        .NUM_LANES (NUM_LANES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_en    (data_en),
        .data       (data),
        .pause      (pause),
        .note_valid (note_valid),
        .note       (note),
        .lane       (lane),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .bad_note   (bad_note)
`ifdef SCHED_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Buffered notes in arrival order; expected outputs after each edge.
    logic [7:0] exp_q[$];
    int         m_beat;
    bit         m_waiting;   // notes known to be buffered, waiting for a beat
    bit         m_emit;      // a note is being presented this cycle
    logic [7:0] m_note;
    logic [2:0] m_lane;
    bit         m_ovf;
    bit         m_bad;
    int         m_drop;

    function automatic bit code_ok(input int d);
        return (d >= NOTE_BASE) && (((d - NOTE_BASE) % NOTE_STEP) == 0)
               && (((d - NOTE_BASE) / NOTE_STEP) < NUM_LANES);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_beat = 0; m_waiting = 0; m_emit = 0;
        m_note = 0; m_lane = 0; m_ovf = 0; m_bad = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit en, input int d, input bit p);
        int  held;
        bit  beat;
        bit  take;
        held = exp_q.size();
        beat = (m_beat == BEAT_DIV - 1) && !p;
        take = m_waiting && beat;
        if (take) begin
            m_note = exp_q.pop_front();
            m_lane = 3'((int'(m_note) - NOTE_BASE) / NOTE_STEP);
        end
        m_bad = en && !code_ok(d);
        if (en && code_ok(d)) begin
            if (held < DEPTH || take) exp_q.push_back(8'(d));
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (m_bad && m_drop < 255) m_drop++;
        if (m_emit)         m_waiting = (held != 0);
        else if (m_waiting) m_waiting = !take;
        else                m_waiting = (held != 0);
        m_emit = take;
        if (!p) m_beat = (m_beat + 1) % BEAT_DIV;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("note_valid", 32'(note_valid), 32'(m_emit));
        check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("bad_note",   32'(bad_note),   32'(m_bad));
        check("note",       32'(note),       32'(m_note));
        check("lane",       32'(lane),       32'(m_lane));
`ifdef SCHED_DROP_COUNT_EN
        check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit en, input int d, input bit p);
        data_en = en; data = 8'(d); pause = p;
        model_step(en, d, p);
        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic do_reset();
        resetn = 1'b1; data_en = 1'b0; data = 8'd0; pause = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b0;
        model_reset();
        check("rst_note_valid", 32'(note_valid), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_overflow",   32'(overflow),   0);
        check("rst_bad_note",   32'(bad_note),   0);
        check("rst_note",       32'(note),       0);
        check("rst_lane",       32'(lane),       0);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       exp_bad;
    } vec_t;

    vec_t vecs[12];
    int   lanes_seen[$];
    int   notes_seen[$];
    int   cyc_seen[$];

    initial begin
        int codes[5];
        bit done;
        codes = '{60, 64, 68, 72, 76};
        resetn = 1'b1; data_en = 1'b0; data = 8'd0; pause = 1'b0;
        model_reset();

        // ---- table: input validation ----
        vecs = '{'{8'd60, 1'b0}, '{8'd64, 1'b0}, '{8'd68, 1'b0}, '{8'd72, 1'b0},
                 '{8'd76, 1'b0}, '{8'd61, 1'b1}, '{8'd80, 1'b1}, '{8'd59, 1'b1},
                 '{8'd0,  1'b1}, '{8'd255, 1'b1}, '{8'd62, 1'b1}, '{8'd77, 1'b1}};
        for (int i = 0; i < 12; i++) begin
            do_reset();
            step(1, int'(vecs[i].code), 1);
            check("tbl_bad_note",   32'(bad_note),   32'(vecs[i].exp_bad));
            check("tbl_fifo_count", 32'(fifo_count), 32'(!vecs[i].exp_bad));
        end

        // ---- 60,64,68 back to back: lanes 0,1,2, one per beat ----
        do_reset();
        lanes_seen.delete(); cyc_seen.delete();
        step(1, 60, 0); step(1, 64, 0); step(1, 68, 0);
        check("seqA_count3", 32'(fifo_count), 3);
        for (int c = 0; c < 20; c++) begin
            step(0, 0, 0);
            if (note_valid) begin lanes_seen.push_back(int'(lane)); cyc_seen.push_back(c); end
        end
        check("seqA_emits", lanes_seen.size(), 3);
        if (lanes_seen.size() == 3) begin
            for (int k = 0; k < 3; k++) check("seqA_lane", lanes_seen[k], k);
            check("seqA_first", cyc_seen[0], 0);
            check("seqA_gap1", cyc_seen[1] - cyc_seen[0], BEAT_DIV);
            check("seqA_gap2", cyc_seen[2] - cyc_seen[1], BEAT_DIV);
        end
        check("seqA_count0", 32'(fifo_count), 0);

        // ---- bad codes only ----
        do_reset();
        step(1, 61, 0); check("bad61", 32'(bad_note), 1);
        step(1, 80, 0); check("bad80", 32'(bad_note), 1);
        step(1, 59, 0); check("bad59", 32'(bad_note), 1);
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 0);
            check("bad_no_emit", 32'(note_valid), 0);
        end

        // ---- overflow with pause, then drain in order ----
        do_reset();
        for (int i = 0; i < 10; i++) step(1, codes[i % 5], 1);
        check("ovf_count8", 32'(fifo_count), 8);
        check("ovf_flag",   32'(overflow),   1);
        notes_seen.delete();
        for (int c = 0; c < 60; c++) begin
            step(0, 0, 0);
            if (note_valid) notes_seen.push_back(int'(note));
        end
        check("ovf_emits", notes_seen.size(), 8);
        for (int k = 0; k < notes_seen.size() && k < 8; k++)
            check("ovf_order", notes_seen[k], codes[k % 5]);
        check("ovf_sticky", 32'(overflow), 1);

        // ---- pause 6 cycles mid-stream ----
        do_reset();
        step(1, 60, 0); step(1, 64, 0);
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            step(0, 0, 0);
            done = note_valid;
        end
        check("pause_first_emit", 32'(done), 1);
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 1);
            check("pause_quiet", 32'(note_valid), 0);
        end
        cyc_seen.delete();
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 0);
            if (note_valid) cyc_seen.push_back(c);
        end
        check("pause_resume_n", cyc_seen.size(), 1);
        if (cyc_seen.size() == 1) check("pause_resume_at", cyc_seen[0], BEAT_DIV - 1);

        // ---- reset with 5 buffered, then one note ----
        do_reset();
        for (int i = 0; i < 5; i++) step(1, codes[i], 1);
        check("mid_count5", 32'(fifo_count), 5);
        do_reset();
        cyc_seen.delete();
        step(1, 72, 0);
        if (note_valid) cyc_seen.push_back(0);
        for (int c = 1; c < 10; c++) begin
            step(0, 0, 0);
            if (note_valid) cyc_seen.push_back(c);
        end
        check("mid_emits", cyc_seen.size(), 1);
        if (cyc_seen.size() == 1) check("mid_latency", cyc_seen[0], BEAT_DIV - 1);
        check("mid_lane", 32'(lane), 3);

        // ---- write on the pop cycle of a full FIFO ----
        do_reset();
        for (int i = 0; i < 8; i++) step(1, codes[i % 5], 1);
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (m_waiting && m_beat == BEAT_DIV - 1) begin
                step(1, 76, 0);
                done = 1;
            end else begin
                step(0, 0, 0);
            end
        end
        check("full_pop_seen",  32'(done),       1);
        check("full_pop_count", 32'(fifo_count), 8);
        check("full_pop_ovf",   32'(overflow),   0);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit en;
            int d;
            bit p;
            en = ($urandom_range(0, 99) < 60);
            d  = ($urandom_range(0, 1) == 1) ? codes[$urandom_range(0, 4)]
                                              : int'($urandom_range(0, 255));
            p  = ($urandom_range(0, 99) < 20);
            if (c == 300) do_reset();
            step(en, d, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
